// File: rtl/axis_bf_pkg.sv
// Shared types and default widths for the AXI-Stream weight sequencer.
package axis_bf_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int SDATA_WIDTH_DEF  = 128;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int NUM_WEIGHTS_DEF  = 4;
  localparam int LEN_WIDTH_DEF    = 16;
  localparam int WEIGHT_BUS_W     = WEIGHT_WIDTH_DEF + 1;

endpackage

// File: rtl/axis_frame_counter.sv
// Beat/frame counter pair: latches frame geometry on load, flags last beat and last frame.
module axis_frame_counter #(
  parameter int LEN_WIDTH = 16,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [LEN_WIDTH-1:0] i_frame_len,
  input  logic [LEN_WIDTH-1:0] i_num_frames,
  input  logic                 i_adv,
  output logic [IDX_W-1:0]     o_frame_idx,
  output logic                 o_last_beat,
  output logic                 o_last_frame
);

  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_num;
  logic [LEN_WIDTH-1:0] r_beat_cnt;
  logic [LEN_WIDTH-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_num       <= '0;
      r_beat_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (i_load) begin
      r_len       <= i_frame_len;
      r_num       <= i_num_frames;
      r_beat_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (i_adv) begin
      // frame_cnt never exceeds num_frames, so it cannot wrap
      if (o_last_beat) begin
        r_beat_cnt  <= '0;
        r_frame_cnt <= r_frame_cnt + LEN_WIDTH'(1);
      end else begin
        r_beat_cnt  <= r_beat_cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign o_last_beat  = (r_beat_cnt == r_len - LEN_WIDTH'(1));
  assign o_last_frame = (r_frame_cnt == r_num - LEN_WIDTH'(1));
  assign o_frame_idx  = r_frame_cnt[IDX_W-1:0];

endmodule

// File: rtl/axis_weight_sequencer.sv
// Frames an AXI-Stream sample stream and sequences per-frame weights to the multiplier.
module axis_weight_sequencer
  import axis_bf_pkg::*;
#(
  parameter int SDATA_WIDTH  = SDATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int NUM_WEIGHTS  = NUM_WEIGHTS_DEF,
  parameter int LEN_WIDTH    = LEN_WIDTH_DEF
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_WEIGHTS)-1:0] cfg_addr,
  input  logic [WEIGHT_WIDTH:0]        cfg_wdata,
  input  logic [LEN_WIDTH-1:0]         frame_len,
  input  logic [LEN_WIDTH-1:0]         num_frames,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [SDATA_WIDTH-1:0]       s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [SDATA_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [WEIGHT_WIDTH:0]        weight
);

  localparam int AW = $clog2(NUM_WEIGHTS);
  localparam int WB = WEIGHT_WIDTH + 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [WB-1:0]   r_table [NUM_WEIGHTS];
  logic [WB-1:0]   r_weight;
  logic            r_done;
  logic            r_cfg_err;
  logic            w_run;
  logic            w_fields_ok;
  logic            w_start_ok;
  logic            w_hs;
  logic            w_last_beat;
  logic            w_last_frame;
  logic            w_run_end;
  logic [AW-1:0]   w_frame_idx;
  logic [WB-1:0]   w_first_weight;

  assign w_run       = (r_state == ST_RUN);
  assign w_fields_ok = (frame_len != '0) && (num_frames != '0);
  assign w_start_ok  = !w_run && start && w_fields_ok;
  assign w_hs        = w_run && s_axis_tvalid && m_axis_tready;
  assign w_run_end   = w_hs && w_last_beat && w_last_frame;

  assign m_axis_tvalid = s_axis_tvalid & w_run;
  assign s_axis_tready = m_axis_tready & w_run;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = w_run & w_last_beat;

  assign busy    = w_run;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;
  assign weight  = r_weight;

  // A table write issued together with start must reach the first frame's weight
  assign w_first_weight = (cfg_we && cfg_addr == '0) ? cfg_wdata : r_table[0];

  axis_frame_counter #(
    .LEN_WIDTH (LEN_WIDTH),
    .IDX_W     (AW)
  ) u_frame_counter (
    .clk          (CLK),
    .rst_n        (resetn),
    .i_load       (w_start_ok),
    .i_frame_len  (frame_len),
    .i_num_frames (num_frames),
    .i_adv        (w_hs),
    .o_frame_idx  (w_frame_idx),
    .o_last_beat  (w_last_beat),
    .o_last_frame (w_last_frame)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_end)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) r_table[i] <= '0;
      r_weight  <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      if (!w_run && cfg_we) r_table[cfg_addr] <= cfg_wdata;
      if (w_start_ok) begin
        r_weight <= w_first_weight;
      end else if (w_hs && w_last_beat) begin
        r_weight <= r_table[w_frame_idx + AW'(1)];
      end
      r_done    <= w_run_end;
      r_cfg_err <= (!w_run && start && !w_fields_ok) || (w_run && cfg_we);
    end
  end

endmodule

// File: tb/tb_axis_weight_sequencer.sv
// Randomized bench for axis_weight_sequencer against a beat-indexed reference model.
module tb_axis_weight_sequencer;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [8:0]   cfg_wdata;
  logic [15:0]  frame_len;
  logic [15:0]  num_frames;
  logic         start;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [8:0]   weight;

  int n_checks = 0;
  int n_errors = 0;
  int tbl_m [4];

  axis_weight_sequencer dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .frame_len     (frame_len),
    .num_frames    (num_frames),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .weight        (weight)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first cycle after start is sampled
  task automatic pulse_start(input int L, input int F);
    frame_len  = 16'(L);
    num_frames = 16'(F);
    start      = 1'b1;
    @(posedge CLK); #1;
    start      = 1'b0;
    frame_len  = 16'($urandom_range(0, 9));
    num_frames = 16'($urandom_range(0, 9));
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(addr);
    cfg_wdata = 9'(data);
    @(posedge CLK); #1;
    cfg_we    = 1'b0;
  endtask

  // Beat k of a run: last when k mod L == L-1, weight from table entry (k div L) mod 4
  task automatic stream_check(input int L, input int F, input bit stall, input int stop_at);
    int k;
    int cyc;
    logic [127:0] d;
    k = 0;
    cyc = 0;
    d = rnd128();
    while (k < stop_at && cyc < 3000) begin
      s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = d;
      #3;
      chk("busy_run", 128'(busy), 128'(1));
      chk("done_run", 128'(done), 128'(0));
      chk("tvalid_gate", 128'(m_axis_tvalid), 128'(s_axis_tvalid));
      chk("tready_gate", 128'(s_axis_tready), 128'(m_axis_tready));
      chk("tlast", 128'(m_axis_tlast), 128'((k % L) == (L - 1)));
      chk("weight", 128'(weight), 128'(tbl_m[(k / L) % 4]));
      if (s_axis_tvalid && m_axis_tready) begin
        chk("tdata", m_axis_tdata, d);
        k++;
        d = rnd128();
      end
      @(posedge CLK); #1;
      cyc++;
    end
    chk("beats", 128'(k), 128'(stop_at));
    if (k == L * F) begin
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      #3;
      chk("done_pulse", 128'(done), 128'(1));
      chk("busy_end", 128'(busy), 128'(0));
      chk("tvalid_idle", 128'(m_axis_tvalid), 128'(0));
      chk("tready_idle", 128'(s_axis_tready), 128'(0));
      chk("tlast_idle", 128'(m_axis_tlast), 128'(0));
      @(posedge CLK); #1;
      chk("done_once", 128'(done), 128'(0));
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic run_check(input int L, input int F, input bit stall);
    pulse_start(L, F);
    stream_check(L, F, stall, L * F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn        = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_wdata     = '0;
    frame_len     = '0;
    num_frames    = '0;
    start         = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tdata  = '0;
    for (int i = 0; i < 4; i++) tbl_m[i] = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("rst_weight", 128'(weight), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
    resetn = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 4; i++) begin
      cfg_write(i, 10 * (i + 1));
      tbl_m[i] = 10 * (i + 1);
    end

    run_check(3, 6, 1'b0);
    run_check(3, 6, 1'b1);

    // zero-length and zero-count starts are rejected
    pulse_start(0, 6);
    chk("err_len0", 128'(cfg_err), 128'(1));
    chk("err_len0_busy", 128'(busy), 128'(0));
    @(posedge CLK); #1;
    chk("err_pulse_end", 128'(cfg_err), 128'(0));
    pulse_start(4, 0);
    chk("err_num0", 128'(cfg_err), 128'(1));
    chk("err_num0_busy", 128'(busy), 128'(0));
    @(posedge CLK); #1;

    // start ignored and table write rejected while running
    s_axis_tvalid = 1'b0;
    pulse_start(3, 2);
    frame_len = '0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("start_in_run_err", 128'(cfg_err), 128'(0));
    cfg_write(2, 77);
    chk("write_in_run_err", 128'(cfg_err), 128'(1));
    stream_check(3, 2, 1'b1, 6);
    run_check(2, 4, 1'b1);

    run_check(1, 5, 1'b0);

    // write landing in the same cycle as the accepted start
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_wdata = 9'd55;
    tbl_m[0] = 55;
    pulse_start(2, 3);
    cfg_we = 1'b0;
    chk("same_cycle_err", 128'(cfg_err), 128'(0));
    stream_check(2, 3, 1'b1, 6);

    for (int r = 0; r < 4; r++) begin
      int a;
      int v;
      a = $urandom_range(0, 3);
      v = $urandom_range(0, 511);
      cfg_write(a, v);
      tbl_m[a] = v;
      run_check($urandom_range(1, 4), $urandom_range(1, 7), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of frame 2
    pulse_start(3, 6);
    stream_check(3, 6, 1'b0, 4);
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_weight", 128'(weight), 128'(0));
    chk("arst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("arst_tready", 128'(s_axis_tready), 128'(0));
    chk("arst_tlast", 128'(m_axis_tlast), 128'(0));
    @(posedge CLK); #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) tbl_m[i] = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      chk("post_rst_done", 128'(done), 128'(0));
      chk("post_rst_busy", 128'(busy), 128'(0));
    end
    s_axis_tvalid = 1'b0;
    run_check(2, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_weight_sequencer.md
# axis_weight_sequencer

Run-time controller in front of the AXI-Stream weight multiplier. It holds a small table of per-frame weights and gates the sample stream into frames of a programmed length. For each frame it presents the selected weight on the multiplier's weight input and generates `tlast` on the last beat. Software loads the table, programs frame length and frame count, and pulses `start`; the block sequences weights frame by frame and signals `done`.

## Interface
- `SDATA_WIDTH`, 128, sample-stream data width (16 × 8-bit samples).
- `WEIGHT_WIDTH`, 8, weight magnitude width; weight bus is `WEIGHT_WIDTH+1` bits, matching the multiplier weight input.
- `NUM_WEIGHTS`, 4, weight-table depth; power of two, ≥2.
- `LEN_WIDTH`, 16, width of the frame-length and frame-count fields.

Ports:
- `CLK`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  $clog2(NUM_WEIGHTS)  table write address.
- `cfg_wdata`  in  WEIGHT_WIDTH+1  table write data.
- `frame_len`  in  LEN_WIDTH  beats per frame; sampled at `start`.
- `num_frames`  in  LEN_WIDTH  frames per run; sampled at `start`.
- `start`  in  1  single-cycle run request.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at end of run.
- `cfg_err`  out  1  one-cycle pulse: rejected `start` or rejected table write.
- `s_axis_tvalid`, `s_axis_tready`, `s_axis_tdata`  in/out/in  1/1/SDATA_WIDTH  upstream samples. Upstream `tlast` is not used.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tdata`, `m_axis_tlast`  out/in/out/out  1/1/SDATA_WIDTH/1  stream to the multiplier.
- `weight`  out  WEIGHT_WIDTH+1  current weight, driving the multiplier weight input.

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on `start` when `frame_len≠0` and `num_frames≠0`. On that edge: latch both fields, and clear `beat_cnt` and `frame_cnt`.
  - `start` with either field zero stays in IDLE and pulses `cfg_err`.
  - RUN→IDLE on the handshake of the last beat of the last frame. `done` pulses in the following cycle.
- Gating is combinational:
  - `m_axis_tvalid = s_axis_tvalid & RUN`
  - `s_axis_tready = m_axis_tready & RUN`
  - `m_axis_tdata = s_axis_tdata`
- Handshake is `m_axis_tvalid & m_axis_tready`. `beat_cnt` increments on each handshake.
- `m_axis_tlast = RUN & (beat_cnt == frame_len_q−1)`.
- On a `tlast` handshake: `beat_cnt`←0 and `frame_cnt`++.
- `weight = table[frame_cnt mod NUM_WEIGHTS]`. The index wraps through the table; the weight changes only at frame boundaries.
- Table writes:
  - Accepted in IDLE only.
  - A write during RUN is dropped and pulses `cfg_err`.
  - A write in the same cycle as an accepted `start` is accepted; it lands before the first frame's weight is used.
- `start` during RUN is ignored (no error pulse).
- Field changes on `frame_len`/`num_frames` after `start` have no effect until the next run.

## Timing
- Reset values:
  - FSM = IDLE; `busy`, `done`, `cfg_err` = 0.
  - `beat_cnt`, `frame_cnt` = 0; all table entries = 0.
  - `weight` = 0; `m_axis_tvalid`, `m_axis_tlast`, `s_axis_tready` = 0.
- Reset mid-run aborts immediately: no `done`, and the partial frame is discarded.
- Stream latency is 0 cycles (combinational passthrough). `weight` is registered: it updates the cycle after the `tlast` handshake.
- `busy` rises the cycle after an accepted `start`. The first beat can be accepted in that same cycle.
- Backpressure (`m_axis_tready=0`) holds all counters.
- `frame_len=1`: `tlast` is on every beat and the weight advances every beat.
- Counters are LEN_WIDTH wide; max run is (2^LEN_WIDTH−1) frames × (2^LEN_WIDTH−1) beats, with no overflow.

## Structure
- Package `axis_bf_pkg`: FSM state enum, default widths, and weight-bus width constant `WEIGHT_BUS_W = WEIGHT_WIDTH+1`.
- One sub-module, `axis_frame_counter`: the beat/frame counter pair with a `tlast` compare and a last-frame flag. The FSM, table and gating live in the top module.

## Test plan
- Load table {10,20,30,40}, `frame_len=3`, `num_frames=6`, sink always ready → 18 beats. `tlast` on beats 3,6,…,18. Weights 10,20,30,40,10,20. `done` one cycle after beat 18.
- Same run with random `m_axis_tready` and `s_axis_tvalid` stalls → beat/weight sequence identical; no beat lost or duplicated.
- `start` with `frame_len=0` → `cfg_err` pulse, `busy` stays 0. Table write during RUN → `cfg_err` pulse, table unchanged (read back via `weight` on the next run).
- `frame_len=1`, `num_frames=5` → `tlast` every beat; weight 10,20,30,40,10.
- Assert `resetn` low mid-frame 2 → all outputs reach reset values asynchronously, no `done`. A new `start` runs cleanly from frame 0 with all table entries 0.
